// File: rtl/byte_data_memory_if.sv
// Request/response bus between a load/store requester and byte_data_memory.
// The master issues requests and drains responses; the slave is the memory.
interface byte_data_memory_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 6
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic                     resp_write;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_write
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_write
  );
endinterface

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory with sized, aligned little-endian loads/stores,
// a one-deep registered response stage and a combinational debug word port.
module byte_data_memory #(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned ADDRESS_WIDTH    = 6,
  parameter int unsigned INIT_STRIDE_FILL = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  byte_data_memory_if.slave                                 bus,
  input  logic [ADDRESS_WIDTH-$clog2(DATA_WIDTH/8)-1:0]     dbg_addr,
  output logic [DATA_WIDTH-1:0]                             dbg_rdata
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned DEPTH      = 2 ** ADDRESS_WIDTH;
  localparam int unsigned MEM_W      = DEPTH * 8;
  localparam int unsigned LANE_SHIFT = $clog2(DATA_WIDTH);
  localparam int unsigned IDX_W      = ADDRESS_WIDTH + 3;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("byte_data_memory: DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  // Power-up image: byte k*BYTES holds k+1 when stride fill is enabled.
  function automatic logic [MEM_W-1:0] init_image();
    logic [MEM_W-1:0] img;
    img = '0;
    if (INIT_STRIDE_FILL != 0) begin
      for (int unsigned k = 0; k < DEPTH / BYTES; k++) begin
        img[k*BYTES*8 +: 8] = 8'(k + 1);
      end
    end
    return img;
  endfunction

  // Byte storage is flat so the debug port can slice a whole word directly.
  logic [MEM_W-1:0]      mem_q = init_image();
  logic [MEM_W-1:0]      mem_d;

  state_e                state_q;
  logic                  resp_err_q;
  logic                  resp_write_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  logic                  req_ready_c;
  logic                  accept_c;
  logic                  size_ok_c;
  logic                  aligned_c;
  logic                  access_ok_c;
  logic                  wr_en_c;
  logic                  sign_c;
  logic                  fill_c;
  int unsigned           n_bytes_c;
  logic [IDX_W-1:0]      lane_idx_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  assign req_ready_c = (state_q == ST_IDLE) || bus.resp_ready;
  assign accept_c    = bus.req_valid && req_ready_c;

  // Request decode: legality, alignment and store enable.
  always_comb begin
    n_bytes_c   = 32'(1) << bus.req_size;
    size_ok_c   = !(bus.req_size == 2'b11 && DATA_WIDTH == 32);
    aligned_c   = (bus.req_addr & ADDRESS_WIDTH'(n_bytes_c - 1)) == '0;
    access_ok_c = size_ok_c && aligned_c;
    wr_en_c     = rst_n && accept_c && access_ok_c && bus.req_write;
    sign_c      = mem_q[{bus.req_addr + ADDRESS_WIDTH'(n_bytes_c - 1), 3'b111}];
    fill_c      = sign_c && !bus.req_unsigned;
  end

  // Byte lanes: gather load data (extended above the access size) and merge store data.
  always_comb begin
    mem_d       = mem_q;
    load_data_c = '0;
    lane_idx_c  = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_idx_c = {bus.req_addr + ADDRESS_WIDTH'(i), 3'b000};
      if (i < n_bytes_c) begin
        load_data_c[8*i +: 8] = mem_q[lane_idx_c +: 8];
        if (wr_en_c) begin
          mem_d[lane_idx_c +: 8] = bus.req_wdata[8*i +: 8];
        end
      end else begin
        load_data_c[8*i +: 8] = {8{fill_c}};
      end
    end
  end

  // Memory contents survive reset; writes are only taken while out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Response stage: IDLE holds nothing, RESP holds a response until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      resp_err_q   <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q      <= ST_RESP;
            resp_err_q   <= !access_ok_c;
            resp_write_q <= bus.req_write;
            resp_rdata_q <= (access_ok_c && !bus.req_write) ? load_data_c : '0;
          end
        end
        ST_RESP: begin
          if (accept_c) begin
            state_q      <= ST_RESP;
            resp_err_q   <= !access_ok_c;
            resp_write_q <= bus.req_write;
            resp_rdata_q <= (access_ok_c && !bus.req_write) ? load_data_c : '0;
          end else if (bus.resp_ready) begin
            state_q      <= ST_IDLE;
            resp_err_q   <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_write = resp_write_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign dbg_rdata = mem_q[{dbg_addr, {LANE_SHIFT{1'b0}}} +: DATA_WIDTH];

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: directed vector table, hand-written handshake and
// reset sequences, then randomized traffic against a byte-array reference model.
module tb_byte_data_memory;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NVEC  = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_data_memory_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_rdata;

  byte_data_memory #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INIT_STRIDE_FILL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_mem [DEPTH];
  logic        m_valid;
  logic        m_err;
  logic        m_write;
  logic [63:0] m_rdata;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [5:0]  a;
    logic [63:0] wd;
    logic [2:0]  dbg;
    logic        err;
    logic [63:0] rd;
    logic [63:0] dbg_exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Reference: memory as a plain byte array, accesses by arithmetic on size/address.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                              input int unsigned a, input logic [63:0] wd,
                              output logic err, output logic [63:0] rd);
    int unsigned n;
    bit ok;
    n   = 1 << sz;
    ok  = ((a % n) == 0) && !(sz == 2'd3 && DW == 32);
    err = !ok;
    rd  = '0;
    if (ok) begin
      if (w) begin
        for (int unsigned i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        for (int unsigned i = 0; i < n; i++) rd = rd | (64'(ref_mem[a+i]) << (8*i));
        if (!u && n < 8 && rd[8*n-1]) rd = rd | (~64'h0 << (8*n));
      end
    end
  endtask

  function automatic logic [63:0] model_dbg(input int unsigned widx);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 8; i++) v = v | (64'(ref_mem[widx*8+i]) << (8*i));
    return v;
  endfunction

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [5:0] a, input logic [63:0] wd);
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  // One request accepted at the next edge; returns #1 after that edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [5:0] a, input logic [63:0] wd);
    logic        e;
    logic [63:0] r;
    set_req(w, sz, u, a, wd);
    @(posedge clk);
    model_access(w, sz, u, 32'(a), wd, e, r);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        e;
    logic [63:0] r;
    int unsigned n;
    int unsigned addr;
    logic        exp_ready;

    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = (i % 8 == 0) ? 8'(i / 8 + 1) : 8'h00;

    vecs[0]  = '{1'b0, 2'd3, 1'b1, 6'h08, 64'h0,                   3'd1, 1'b0, 64'h2,                   64'h2};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 6'h10, 64'h0000_0000_1234_8001, 3'd2, 1'b0, 64'h0,                   64'h8001};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 6'h10, 64'h0,                   3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 64'h8001};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 6'h10, 64'h0,                   3'd2, 1'b0, 64'h8001,                64'h8001};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 6'h06, 64'hDEAD_BEEF,           3'd0, 1'b1, 64'h0,                   64'h1};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 6'h04, 64'h0,                   3'd0, 1'b1, 64'h0,                   64'h1};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 6'h3F, 64'h0000_0000_0000_77A5, 3'd7, 1'b0, 64'h0,                   64'hA500_0000_0000_0008};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 6'h3F, 64'h0,                   3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFA5, 64'hA500_0000_0000_0008};
    vecs[8]  = '{1'b0, 2'd2, 1'b1, 6'h38, 64'h0,                   3'd7, 1'b0, 64'h8,                   64'hA500_0000_0000_0008};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 6'h00, 64'h0,                   3'd0, 1'b0, 64'h1,                   64'h1};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 6'h03, 64'h0,                   3'd3, 1'b1, 64'h0,                   64'h4};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 6'h18, 64'h1122_3344_5566_7788, 3'd3, 1'b0, 64'h0,                   64'h1122_3344_5566_7788};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 6'h1C, 64'h0,                   3'd3, 1'b0, 64'h1122_3344,           64'h1122_3344_5566_7788};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 6'h3F, 64'h0,                   3'd7, 1'b0, 64'hA5,                  64'hA500_0000_0000_0008};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1; dbg_addr = 3'd1;

    // Reset values, with a request presented that must not leave a response.
    bus.req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'h0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'h1);
    chk("reset_resp_err", 64'(bus.resp_err), 64'h0);
    chk("reset_resp_write", 64'(bus.resp_write), 64'h0);
    chk("reset_resp_rdata", bus.resp_rdata, 64'h0);
    chk("reset_dbg_init", dbg_rdata, 64'h2);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table; the first request lands on the first edge out of reset.
    for (int i = 0; i < int'(NVEC); i++) begin
      dbg_addr = vecs[i].dbg;
      issue(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d_valid", i), 64'(bus.resp_valid), 64'h1);
      chk($sformatf("vec%0d_err", i), 64'(bus.resp_err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_write", i), 64'(bus.resp_write), 64'(vecs[i].w));
      chk($sformatf("vec%0d_rdata", i), bus.resp_rdata, vecs[i].rd);
      chk($sformatf("vec%0d_dbg", i), dbg_rdata, vecs[i].dbg_exp);
    end
    drain();
    chk("drain_idle", 64'(bus.resp_valid), 64'h0);

    // Backpressure: held response stays put, pending store is ignored, then accepted.
    bus.resp_ready = 1'b0;
    dbg_addr = 3'd1;
    issue(1'b0, 2'd3, 1'b1, 6'h08, 64'h0);
    set_req(1'b1, 2'd0, 1'b0, 6'h08, 64'h5A);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 64'(bus.req_ready), 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", c), 64'(bus.resp_valid), 64'h1);
      chk($sformatf("bp%0d_rdata", c), bus.resp_rdata, 64'h2);
      chk($sformatf("bp%0d_err", c), 64'(bus.resp_err), 64'h0);
      chk($sformatf("bp%0d_mem", c), dbg_rdata, 64'h2);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.req_ready), 64'h1);
    @(posedge clk);
    model_access(1'b1, 2'd0, 1'b0, 32'h08, 64'h5A, e, r);
    #1;
    bus.req_valid = 1'b0;
    chk("bp_store_valid", 64'(bus.resp_valid), 64'h1);
    chk("bp_store_write", 64'(bus.resp_write), 64'h1);
    chk("bp_store_rdata", bus.resp_rdata, 64'h0);
    chk("bp_store_mem", dbg_rdata, 64'h5A);

    // Back-to-back store then signed load of the same byte.
    drain();
    issue(1'b1, 2'd0, 1'b0, 6'h21, 64'h7E);
    chk("b2b_store_err", 64'(bus.resp_err), 64'h0);
    issue(1'b0, 2'd0, 1'b0, 6'h21, 64'h0);
    chk("b2b_load_rdata", bus.resp_rdata, 64'h7E);

    // Reset between edges while a response is held.
    drain();
    bus.resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b1, 6'h10, 64'h0);
    chk("mid_rst_pre_valid", 64'(bus.resp_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.resp_valid), 64'h0);
    chk("mid_rst_rdata", bus.resp_rdata, 64'h0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b1, 6'h10, 64'h0);
    chk("post_rst_rdata", bus.resp_rdata, 64'h8001);
    drain();

    // Randomized traffic against the reference model.
    m_valid = 1'b0; m_err = 1'b0; m_write = 1'b0; m_rdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.req_valid    = ($urandom % 4) != 0;
      bus.resp_ready   = ($urandom % 3) != 0;
      bus.req_write    = $urandom % 2;
      bus.req_size     = 2'($urandom % 4);
      bus.req_unsigned = $urandom % 2;
      n    = 1 << bus.req_size;
      addr = $urandom % DEPTH;
      if (($urandom % 4) != 0) addr = addr - (addr % n);
      bus.req_addr  = 6'(addr);
      bus.req_wdata = {$urandom, $urandom};
      dbg_addr      = 3'($urandom % 8);
      #1;
      exp_ready = !m_valid || bus.resp_ready;
      chk("rnd_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("rnd_dbg", dbg_rdata, model_dbg(32'(dbg_addr)));
      @(posedge clk);
      if (bus.req_valid && exp_ready) begin
        model_access(bus.req_write, bus.req_size, bus.req_unsigned, 32'(bus.req_addr),
                     bus.req_wdata, e, r);
        m_valid = 1'b1; m_err = e; m_write = bus.req_write; m_rdata = r;
      end else if (bus.resp_ready) begin
        m_valid = 1'b0;
      end
      #1;
      chk("rnd_valid", 64'(bus.resp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_err", 64'(bus.resp_err), 64'(m_err));
        chk("rnd_write", 64'(bus.resp_write), 64'(m_write));
        chk("rnd_rdata", bus.resp_rdata, m_rdata);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
